// File: rtl/ddr_cmd_issue.sv
// rtl/ddr_cmd_issue.sv - DDR command issuer with lock-out timing and data windows
//
// Purpose: accepts {ras_n,cas_n,we_n,ba,a} words, drives each on the DDR pins
// for one cycle (NOP otherwise), locks out further words for a per-command
// number of cycles, and generates the read-capture and write data windows.
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   cba_valid  in   command word available
//   cba_data   in   {ras_n, cas_n, we_n, ba, a}, ras_n at the MSB
//   cba_ready  out  word accepted this cycle if cba_valid is high
//   ddr_ras_n, ddr_cas_n, ddr_we_n, ddr_ba, ddr_a  out  registered pins
//   dqs_oe     out  write output-enable window (preamble + data)
//   dqs_en     out  DQS toggle enable
//   wdata_ack  out  write FIFO pop, one word (two beats) per cycle
//   sample     out  read capture strobe, one cycle per beat pair
//   busy       out  lock-out pending or any window active
module ddr_cmd_issue #(
  parameter int A_WIDTH    = 13,
  parameter int BA_WIDTH   = 2,
  parameter int BURST_LEN  = 4,
  parameter int SAMPLE_DLY = 6,
  parameter int T_MRS      = 2,
  parameter int T_AR       = 14,
  parameter int T_PRE      = 2,
  parameter int T_ACT      = 4,
  parameter int T_READ     = 6,
  parameter int T_WRITE    = 8,
  parameter int DLY_WIDTH  = 5,
  parameter int CBA_W      = 3 + BA_WIDTH + A_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cba_valid,
  input  logic [CBA_W-1:0]    cba_data,
  output logic                cba_ready,
  output logic                ddr_ras_n,
  output logic                ddr_cas_n,
  output logic                ddr_we_n,
  output logic [BA_WIDTH-1:0] ddr_ba,
  output logic [A_WIDTH-1:0]  ddr_a,
  output logic                dqs_oe,
  output logic                dqs_en,
  output logic                wdata_ack,
  output logic                sample,
  output logic                busy
);

  localparam int BC      = BURST_LEN / 2;
  localparam int RD_D    = SAMPLE_DLY + BC;
  localparam int WR_D    = BC + 1;
  localparam int DLY_MAX = (1 << DLY_WIDTH) - 1;

  localparam logic [2:0] CMD_MRS   = 3'b000;
  localparam logic [2:0] CMD_AR    = 3'b001;
  localparam logic [2:0] CMD_PRE   = 3'b010;
  localparam logic [2:0] CMD_ACT   = 3'b011;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_READ  = 3'b101;

  localparam logic [CBA_W-1:0] NOP_WORD = {3'b111, {(CBA_W-3){1'b0}}};

  // Bit k of a window register drives its output k edges after the load edge,
  // so the masks place ones at the output cycles relative to acceptance.
  localparam logic [RD_D-1:0] RD_MASK    = {{BC{1'b1}}, {SAMPLE_DLY{1'b0}}};
  localparam logic [WR_D-1:0] WR_OE_MASK = {WR_D{1'b1}};
  localparam logic [WR_D-1:0] WR_EN_MASK = {{BC{1'b1}}, 1'b0};

  if (BURST_LEN != 2 && BURST_LEN != 4 && BURST_LEN != 8) begin : g_bad_bl
    $error("ddr_cmd_issue: BURST_LEN must be 2, 4 or 8");
  end
  if (SAMPLE_DLY < 1 || SAMPLE_DLY > 15) begin : g_bad_sd
    $error("ddr_cmd_issue: SAMPLE_DLY must be in 1..15");
  end
  if (T_MRS > DLY_MAX || T_AR > DLY_MAX || T_PRE > DLY_MAX ||
      T_ACT > DLY_MAX || T_READ > DLY_MAX || T_WRITE > DLY_MAX) begin : g_bad_t
    $error("ddr_cmd_issue: lock-out value exceeds DLY_WIDTH counter range");
  end

  logic [DLY_WIDTH-1:0] dly_cnt;
  logic [DLY_WIDTH-1:0] dly_load;
  logic [CBA_W-1:0]     pin_q;
  logic [RD_D-1:0]      rd_sr;
  logic [WR_D-1:0]      oe_sr;
  logic [WR_D-1:0]      en_sr;
  logic [2:0]           cmd;
  logic                 accept;

  assign cmd       = cba_data[CBA_W-1 -: 3];
  assign cba_ready = (dly_cnt == '0);
  assign accept    = cba_valid & cba_ready;

  // BST and NOP fall to the default and load zero, allowing back-to-back words.
  always_comb begin
    dly_load = '0;
    case (cmd)
      CMD_MRS:   dly_load = DLY_WIDTH'(T_MRS);
      CMD_AR:    dly_load = DLY_WIDTH'(T_AR);
      CMD_PRE:   dly_load = DLY_WIDTH'(T_PRE);
      CMD_ACT:   dly_load = DLY_WIDTH'(T_ACT);
      CMD_WRITE: dly_load = DLY_WIDTH'(T_WRITE);
      CMD_READ:  dly_load = DLY_WIDTH'(T_READ);
      default:   dly_load = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_q   <= NOP_WORD;
      dly_cnt <= '0;
      rd_sr   <= '0;
      oe_sr   <= '0;
      en_sr   <= '0;
    end else begin
      pin_q <= accept ? cba_data : NOP_WORD;

      if (accept) begin
        dly_cnt <= dly_load;
      end else if (dly_cnt != '0) begin
        dly_cnt <= dly_cnt - DLY_WIDTH'(1);
      end

      // New windows are ORed in so overlapping bursts merge instead of truncating.
      rd_sr <= (rd_sr >> 1) | ((accept && cmd == CMD_READ)  ? RD_MASK    : '0);
      oe_sr <= (oe_sr >> 1) | ((accept && cmd == CMD_WRITE) ? WR_OE_MASK : '0);
      en_sr <= (en_sr >> 1) | ((accept && cmd == CMD_WRITE) ? WR_EN_MASK : '0);
    end
  end

  assign ddr_ras_n = pin_q[CBA_W-1];
  assign ddr_cas_n = pin_q[CBA_W-2];
  assign ddr_we_n  = pin_q[CBA_W-3];
  assign ddr_ba    = pin_q[A_WIDTH +: BA_WIDTH];
  assign ddr_a     = pin_q[A_WIDTH-1:0];

  assign sample    = rd_sr[0];
  assign dqs_oe    = oe_sr[0];
  assign dqs_en    = en_sr[0];
  assign wdata_ack = en_sr[0];
  assign busy      = (dly_cnt != '0) | (|rd_sr) | (|oe_sr) | (|en_sr);

endmodule
